// File: rtl/seq_dispatcher.sv
// seq_dispatcher: queues task start addresses and launches each one
// as a sequencer jump, only while the sequencer reports STOP.
module seq_dispatcher #(
  parameter int aw     = 7,
  parameter int depth  = 16,
  parameter int settle = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [aw-1:0]            req_addr,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     flush,
  input  logic                     seq_stop,
  output logic [aw-1:0]            seq_addr,
  output logic                     seq_jump,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(depth):0]   level
);

  localparam int PW = $clog2(depth);
  localparam int LW = PW + 1;
  localparam int CW = (settle > 1) ? $clog2(settle) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RUN
  } state_t;

  state_t          r_state;
  logic [aw-1:0]   r_mem [depth];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [LW-1:0]   r_level;
  logic [CW-1:0]   r_cnt;
  logic [aw-1:0]   r_addr;
  logic            r_jump;
  logic            r_busy;
  logic            r_done;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;

  assign w_full    = (r_level == LW'(depth));
  assign w_empty   = (r_level == '0);
  assign req_ready = ~w_full & ~flush;
  assign w_push    = req_valid & req_ready;
  assign w_pop     = (r_state == IDLE) & ~w_empty & seq_stop;

  assign seq_addr  = r_addr;
  assign seq_jump  = r_jump;
  assign busy      = r_busy;
  assign done      = r_done;
  assign level     = r_level;

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= req_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      if (w_push & ~w_pop)
        r_level <= r_level + 1'b1;
      else if (w_pop & ~w_push)
        r_level <= r_level - 1'b1;
    end
  end

  // seq_stop is ignored in ISSUE/WAIT while the jump propagates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_jump  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_jump <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state <= ISSUE;
            r_addr  <= r_mem[r_rptr];
            r_jump  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ISSUE: begin
          r_cnt   <= CW'(settle - 1);
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_cnt == '0)
            r_state <= RUN;
          else
            r_cnt <= r_cnt - 1'b1;
        end
        RUN: begin
          if (seq_stop) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
